uart_cmd_engine: RTL and testbench

Parametrised byte-stream command engine placed behind the UART receiver/transmitter pair. It decodes host commands arriving as bytes and drives a small register bank: write register, read register, and read device ID. Multi-byte register data, a ready/valid transmit handshake and an inter-byte timeout are included. Its register bank feeds downstream control logic through a flattened output bus.

---
 rtl/uart_cmd_engine.sv | 200 ++++++++++++++++++++
 tb/tb_uart_cmd_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_engine.sv
// uart_cmd_engine
// Byte-stream command decoder sitting between a UART receiver and transmitter.
// Supports three commands:
//   write register : CMD_WRITE, addr, DATA_BYTES data bytes (MSB first)
//   read register  : CMD_READ, addr  -> DATA_BYTES bytes sent back (MSB first)
//   read device ID : CMD_ID          -> DEVICE_ID sent back
// An inter-byte timeout aborts partially received commands.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   recv, uart_rx         one-cycle strobe with the received byte
//   tx_ready              transmitter accepts uart_tx when send is high
//   send, uart_tx         registered valid/data towards the transmitter
//   reg_out               flattened register bank, reg i at [i*DATA_BYTES*8 +: DATA_BYTES*8]
//   wr_strobe             one-cycle pulse when a register has been updated
//   err                   one-cycle pulse on bad opcode, bad address or timeout
module uart_cmd_engine #(
  parameter int         DATA_BYTES = 2,
  parameter int         ADDR_W     = 3,
  parameter logic [7:0] CMD_WRITE  = 8'd69,
  parameter logic [7:0] CMD_READ   = 8'd42,
  parameter logic [7:0] CMD_ID     = 8'd73,
  parameter logic [7:0] DEVICE_ID  = 8'd111,
  parameter int         TIMEOUT    = 1000
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   recv,
  input  logic [7:0]                             uart_rx,
  input  logic                                   tx_ready,
  output logic                                   send,
  output logic [7:0]                             uart_tx,
  output logic [(2**ADDR_W)*DATA_BYTES*8-1:0]    reg_out,
  output logic                                   wr_strobe,
  output logic                                   err
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam int DW       = DATA_BYTES * 8;
  localparam int CNT_W    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, RX_ADDR, RX_DATA, TX_DATA, TX_ID} state_t;

  state_t              state, state_d;
  logic                op_write, op_write_d;
  logic [ADDR_W-1:0]   addr, addr_d;
  logic [DW-1:0]       buffer, buffer_d;
  logic [DW-1:0]       shifted;
  logic [CNT_W-1:0]    count, count_d;
  logic [TO_W-1:0]     idle_cnt, idle_cnt_d;
  logic                send_d;
  logic [7:0]          tx_d;
  logic                wr_d, err_d;
  logic                reg_we;
  logic                timed_out;
  logic [DW-1:0]       regs [NUM_REGS];

  // Fires on the TIMEOUT-th consecutive edge without recv.
  assign timed_out = (TIMEOUT != 0) && (idle_cnt == TO_LAST);

  always_comb begin
    state_d    = state;
    op_write_d = op_write;
    addr_d     = addr;
    buffer_d   = buffer;
    count_d    = count;
    idle_cnt_d = '0;
    send_d     = send;
    tx_d       = uart_tx;
    wr_d       = 1'b0;
    err_d      = 1'b0;
    reg_we     = 1'b0;
    shifted    = buffer << 8;

    unique case (state)
      IDLE: begin
        send_d = 1'b0;
        tx_d   = '0;
        if (recv) begin
          if (uart_rx == CMD_WRITE || uart_rx == CMD_READ) begin
            op_write_d = (uart_rx == CMD_WRITE);
            state_d    = RX_ADDR;
          end else if (uart_rx == CMD_ID) begin
            state_d = TX_ID;
            send_d  = 1'b1;
            tx_d    = DEVICE_ID;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RX_ADDR: begin
        if (recv) begin
          if ((uart_rx >> ADDR_W) != '0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = uart_rx[ADDR_W-1:0];
            count_d = '0;
            if (op_write) begin
              state_d = RX_DATA;
            end else begin
              // Present the MSB byte straight away so send rises on the next cycle.
              state_d  = TX_DATA;
              buffer_d = regs[uart_rx[ADDR_W-1:0]];
              send_d   = 1'b1;
              tx_d     = buffer_d[DW-1 -: 8];
            end
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          idle_cnt_d = idle_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (recv) begin
          buffer_d = shifted | DW'(uart_rx);
          if (count == CNT_LAST) begin
            reg_we  = 1'b1;
            wr_d    = 1'b1;
            state_d = IDLE;
          end else begin
            count_d = count + 1'b1;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          idle_cnt_d = idle_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        // send is always high in this state, so tx_ready alone marks a transfer.
        if (tx_ready) begin
          buffer_d = shifted;
          if (count == CNT_LAST) begin
            state_d = IDLE;
            send_d  = 1'b0;
            tx_d    = '0;
          end else begin
            count_d = count + 1'b1;
            tx_d    = shifted[DW-1 -: 8];
          end
        end
      end
      TX_ID: begin
        if (tx_ready) begin
          state_d = IDLE;
          send_d  = 1'b0;
          tx_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_write  <= 1'b0;
      addr      <= '0;
      buffer    <= '0;
      count     <= '0;
      idle_cnt  <= '0;
      send      <= 1'b0;
      uart_tx   <= '0;
      wr_strobe <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      op_write  <= op_write_d;
      addr      <= addr_d;
      buffer    <= buffer_d;
      count     <= count_d;
      idle_cnt  <= idle_cnt_d;
      send      <= send_d;
      uart_tx   <= tx_d;
      wr_strobe <= wr_d;
      err       <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[addr] <= buffer_d;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) reg_out[i*DW +: DW] = regs[i];
  end

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Self-checking bench for uart_cmd_engine: directed scenarios followed by
// randomized byte streams, all checked every cycle against a byte-queue model.
module tb_uart_cmd_engine;
  localparam int DB = 2;
  localparam int AW = 3;
  localparam int NR = 1 << AW;
  localparam int DW = DB * 8;
  localparam int CW = NR * DW;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          recv = 1'b0;
  logic [7:0]    uart_rx = '0;
  logic          tx_ready = 1'b0;
  logic          send;
  logic [7:0]    uart_tx;
  logic [CW-1:0] reg_out;
  logic          wr_strobe;
  logic          err;

  uart_cmd_engine #(
    .DATA_BYTES(DB),
    .ADDR_W(AW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .recv(recv),
    .uart_rx(uart_rx),
    .tx_ready(tx_ready),
    .send(send),
    .uart_tx(uart_tx),
    .reg_out(reg_out),
    .wr_strobe(wr_strobe),
    .err(err)
  );

  always #5 clk = ~clk;

  // Model: register contents, bytes of the command being collected, bytes
  // still owed to the transmitter, and one-cycle pulse expectations.
  logic [DW-1:0] m_regs [NR];
  byte unsigned  cmd_q[$];
  byte unsigned  tx_q[$];
  int            idle;
  logic          e_wr, e_err;
  byte unsigned  got_tx[$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    cmd_q.delete();
    tx_q.delete();
    idle  = 0;
    e_wr  = 1'b0;
    e_err = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic [7:0] b, input logic tr);
    logic [DW-1:0] v;
    logic [7:0]    a;
    e_wr  = 1'b0;
    e_err = 1'b0;
    if (tx_q.size() != 0) begin
      if (tr) void'(tx_q.pop_front());
    end else if (r) begin
      idle = 0;
      cmd_q.push_back(b);
      if (cmd_q.size() == 1) begin
        if (b == 8'd73) begin
          tx_q.push_back(8'd111);
          cmd_q.delete();
        end else if (b != 8'd69 && b != 8'd42) begin
          e_err = 1'b1;
          cmd_q.delete();
        end
      end else if (cmd_q.size() == 2) begin
        if (b >= NR) begin
          e_err = 1'b1;
          cmd_q.delete();
        end else if (cmd_q[0] == 8'd42) begin
          v = m_regs[b[AW-1:0]];
          for (int k = DB - 1; k >= 0; k--) tx_q.push_back(v[k*8 +: 8]);
          cmd_q.delete();
        end
      end else if (cmd_q.size() == 2 + DB) begin
        v = '0;
        for (int k = 0; k < DB; k++) v = (v << 8) | DW'(cmd_q[2+k]);
        a = cmd_q[1];
        m_regs[a[AW-1:0]] = v;
        e_wr = 1'b1;
        cmd_q.delete();
      end
    end else if (cmd_q.size() != 0) begin
      idle++;
      if (idle == TO) begin
        e_err = 1'b1;
        cmd_q.delete();
        idle = 0;
      end
    end
  endtask

  task automatic compare();
    logic [CW-1:0] er;
    logic [7:0]    et;
    for (int i = 0; i < NR; i++) er[i*DW +: DW] = m_regs[i];
    et = (tx_q.size() != 0) ? tx_q[0] : 8'd0;
    check("send", CW'(send), CW'(tx_q.size() != 0));
    check("uart_tx", CW'(uart_tx), CW'(et));
    check("wr_strobe", CW'(wr_strobe), CW'(e_wr));
    check("err", CW'(err), CW'(e_err));
    check("reg_out", reg_out, er);
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model, check.
  task automatic cyc(input logic r, input logic [7:0] b, input logic tr);
    recv     = r;
    uart_rx  = b;
    tx_ready = tr;
    if (send && tr) got_tx.push_back(uart_tx);
    @(posedge clk);
    model_step(r, b, tr);
    #2;
    compare();
  endtask

  task automatic do_reset();
    recv     = 1'b0;
    tx_ready = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    compare();
    check("rst_send", CW'(send), '0);
    check("rst_uart_tx", CW'(uart_tx), '0);
    check("rst_reg_out", reg_out, '0);
    check("rst_wr_strobe", CW'(wr_strobe), '0);
    check("rst_err", CW'(err), '0);
    repeat (2) @(posedge clk);
    #1;
    compare();
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [CW-1:0] masked;
  int unsigned   gap, sel;
  logic          rr, tr;
  logic [7:0]    bb;

  initial begin
    do_reset();
    cyc(1'b0, 8'h00, 1'b0);

    // Write 0xABCD to register 3.
    cyc(1'b1, 8'd69, 1'b0);
    cyc(1'b1, 8'd3, 1'b0);
    cyc(1'b1, 8'hAB, 1'b0);
    check("wr_not_early", CW'(wr_strobe), '0);
    cyc(1'b1, 8'hCD, 1'b0);
    check("wr_pulse", CW'(wr_strobe), CW'(1));
    check("model_reg3", CW'(m_regs[3]), CW'(16'hABCD));
    check("reg3", CW'(reg_out[3*DW +: DW]), CW'(16'hABCD));
    masked = reg_out;
    masked[3*DW +: DW] = '0;
    check("others_zero", masked, '0);
    cyc(1'b0, 8'h00, 1'b0);
    check("wr_one_cycle", CW'(wr_strobe), '0);

    // Read register 3 at full rate.
    got_tx.delete();
    cyc(1'b1, 8'd42, 1'b1);
    cyc(1'b1, 8'd3, 1'b1);
    check("rd_first", CW'(uart_tx), CW'(8'hAB));
    cyc(1'b0, 8'h00, 1'b1);
    check("rd_second", CW'(uart_tx), CW'(8'hCD));
    cyc(1'b0, 8'h00, 1'b1);
    check("rd_done", CW'(send), '0);
    check("rd_count", CW'(got_tx.size()), CW'(2));
    check("rd_b0", CW'(got_tx[0]), CW'(8'hAB));
    check("rd_b1", CW'(got_tx[1]), CW'(8'hCD));

    // Read with a 5-cycle transmitter stall.
    got_tx.delete();
    cyc(1'b1, 8'd42, 1'b0);
    cyc(1'b1, 8'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      check("stall_send", CW'(send), CW'(1));
      check("stall_tx", CW'(uart_tx), CW'(8'hAB));
    end
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    check("stall_count", CW'(got_tx.size()), CW'(2));
    check("stall_b0", CW'(got_tx[0]), CW'(8'hAB));
    check("stall_b1", CW'(got_tx[1]), CW'(8'hCD));

    // Device ID.
    cyc(1'b1, 8'd73, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      check("id_tx", CW'(uart_tx), CW'(8'd111));
    end
    cyc(1'b0, 8'h00, 1'b1);
    check("id_done", CW'(send), '0);

    // Unknown opcode and bad address.
    cyc(1'b1, 8'h55, 1'b0);
    check("err_opcode", CW'(err), CW'(1));
    cyc(1'b1, 8'd69, 1'b0);
    check("err_clear", CW'(err), '0);
    cyc(1'b1, 8'h80, 1'b0);
    check("err_addr", CW'(err), CW'(1));
    check("err_regs_kept", CW'(reg_out[3*DW +: DW]), CW'(16'hABCD));

    // Timeout in the middle of a write.
    cyc(1'b1, 8'd69, 1'b0);
    cyc(1'b1, 8'd2, 1'b0);
    cyc(1'b1, 8'h12, 1'b0);
    for (int i = 0; i < TO - 1; i++) cyc(1'b0, 8'h00, 1'b0);
    check("to_not_early", CW'(err), '0);
    cyc(1'b0, 8'h00, 1'b0);
    check("to_fire", CW'(err), CW'(1));
    check("to_reg2", CW'(reg_out[2*DW +: DW]), '0);
    cyc(1'b1, 8'd42, 1'b1);
    check("to_opcode_ok", CW'(err), '0);
    cyc(1'b1, 8'd2, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);

    // Reset between data bytes of a write.
    cyc(1'b1, 8'd69, 1'b0);
    cyc(1'b1, 8'd5, 1'b0);
    cyc(1'b1, 8'h77, 1'b0);
    do_reset();
    cyc(1'b1, 8'h99, 1'b0);
    check("rst_no_wr", CW'(wr_strobe), '0);
    cyc(1'b1, 8'd69, 1'b0);
    cyc(1'b1, 8'd5, 1'b0);
    cyc(1'b1, 8'h12, 1'b0);
    cyc(1'b1, 8'h34, 1'b0);
    check("rst_then_wr", CW'(reg_out[5*DW +: DW]), CW'(16'h1234));

    // Randomized traffic.
    gap = 0;
    for (int n = 0; n < 4000; n++) begin
      if (gap > 0) begin
        gap--;
        rr = 1'b0;
      end else begin
        rr = ($urandom_range(0, 99) < 45);
      end
      sel = $urandom_range(0, 9);
      case (sel)
        0: bb = 8'd69;
        1: bb = 8'd42;
        2: bb = 8'd73;
        3, 4, 5, 6: bb = 8'($urandom_range(0, NR - 1));
        default: bb = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 99) == 0) gap = $urandom_range(TO - 2, TO + 2);
      tr = ($urandom_range(0, 99) < 65);
      cyc(rr, bb, tr);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
